// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider / period tick generator with glitch-free config reload
// Optional completed-period counter (cyc_count) is enabled by defining CLKDIV_CYC_COUNT_EN.
module clk_div_prog #(
    parameter int CNT_WIDTH      = 32,
    parameter int DEFAULT_PERIOD = 20000000,
    parameter int DEFAULT_HIGH   = 10000000,
    parameter int CYC_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic                 cfg_err,
    output logic                 clk_div_out,
    output logic                 tick
`ifdef CLKDIV_CYC_COUNT_EN
    ,
    output logic [CYC_WIDTH-1:0] cyc_count
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] RST_HIGH   = CNT_WIDTH'(DEFAULT_HIGH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO    = CNT_WIDTH'(2);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic [CNT_WIDTH-1:0] shd_period_q, shd_period_d;
    logic [CNT_WIDTH-1:0] shd_high_q, shd_high_d;
    logic                 pending_q, pending_d;
    logic                 err_q, err_d;
    logic                 out_q, out_d;
    logic                 tick_q, tick_d;

    logic                 cfg_fire;
    logic                 cfg_ok;
    logic                 cnt_last;
    logic                 run_wrap;
    logic                 apply;

    // Ready is simply "no shadow config waiting", so it is a registered output.
    assign cfg_fire = cfg_valid && !pending_q;
    assign cfg_ok   = (cfg_period >= CNT_TWO) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign cnt_last = (cnt_q == (period_q - CNT_ONE));
    assign run_wrap = (state_q == ST_RUN) && en && cnt_last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            period_q     <= RST_PERIOD;
            high_q       <= RST_HIGH;
            shd_period_q <= RST_PERIOD;
            shd_high_q   <= RST_HIGH;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            out_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            shd_period_q <= shd_period_d;
            shd_high_q   <= shd_high_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            out_q        <= out_d;
            tick_q       <= tick_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d        = cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        shd_period_d = shd_period_q;
        shd_high_d   = shd_high_q;
        pending_d    = pending_q;
        apply        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                apply = pending_q;
            end
            ST_RUN: begin
                if (!en) begin
                    cnt_d = '0;
                end else if (run_wrap) begin
                    cnt_d = '0;
                    apply = pending_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: cnt_d = '0;
        endcase

        // A pending config only switches in at a period boundary or while idle.
        if (apply) begin
            period_d  = shd_period_q;
            high_d    = shd_high_q;
            pending_d = 1'b0;
        end

        if (cfg_fire && cfg_ok) begin
            shd_period_d = cfg_period;
            shd_high_d   = cfg_high;
            pending_d    = 1'b1;
        end

        err_d  = cfg_fire && !cfg_ok;
        out_d  = (state_d == ST_RUN) && (cnt_d < high_d);
        tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    end

    assign cfg_ready   = !pending_q;
    assign cfg_err     = err_q;
    assign clk_div_out = out_q;
    assign tick        = tick_q;

`ifdef CLKDIV_CYC_COUNT_EN
    logic [CYC_WIDTH-1:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (run_wrap) begin
            cyc_d = cyc_q + CYC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc_count = cyc_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog (8-bit, default 10/5)
module tb_clk_div_prog;

    localparam int CW = 8;
    localparam int YW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_high;
    logic          cfg_err;
    logic          clk_div_out;
    logic          tick;
`ifdef CLKDIV_CYC_COUNT_EN
    logic [YW-1:0] cyc_count;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_prog #(
        .CNT_WIDTH      (CW),
        .DEFAULT_PERIOD (10),
        .DEFAULT_HIGH   (5),
        .CYC_WIDTH      (YW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .clk_div_out (clk_div_out),
        .tick        (tick)
`ifdef CLKDIV_CYC_COUNT_EN
        ,
        .cyc_count   (cyc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check out/tick for n cycles of a period/high waveform starting at phase start, advancing one cycle each.
    task automatic check_wave(input string tag, input int n, input int period, input int high, input int start);
        int ph;
        for (int i = 0; i < n; i++) begin
            ph = (start + i) % period;
            check_eq({tag, "_out"},  {31'b0, clk_div_out}, (ph < high) ? 32'd1 : 32'd0);
            check_eq({tag, "_tick"}, {31'b0, tick},        (ph == 0)   ? 32'd1 : 32'd0);
            step();
        end
    endtask

    task automatic offer(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = CW'(p);
        cfg_high   = CW'(h);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        step();
        step();
        check_eq("rst_ready", {31'b0, cfg_ready},   32'd1);
        check_eq("rst_err",   {31'b0, cfg_err},     32'd0);
        check_eq("rst_out",   {31'b0, clk_div_out}, 32'd0);
        check_eq("rst_tick",  {31'b0, tick},        32'd0);
`ifdef CLKDIV_CYC_COUNT_EN
        check_eq("rst_cyc",   {24'b0, cyc_count},   32'd0);
`endif

        // Default 10/5 waveform
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check_wave("dflt", 20, 10, 5, 0);

        // Mid-period config 4/1 accepted at cnt=3
        check_wave("pre_cfg", 3, 10, 5, 0);
        offer(4, 1);
        check_wave("acc_cfg", 1, 10, 5, 3);
        cfg_valid = 1'b0;
        check_eq("ready_low_c4", {31'b0, cfg_ready}, 32'd0);
        check_wave("old_tail", 5, 10, 5, 4);
        check_eq("ready_low_c9", {31'b0, cfg_ready}, 32'd0);
        check_wave("old_last", 1, 10, 5, 9);
        check_eq("ready_after_sw", {31'b0, cfg_ready}, 32'd1);
        check_wave("p4h1", 12, 4, 1, 0);

        // Invalid configs: period=1/high=0, period=6/high=6
        offer(1, 0);
        check_wave("inv1_cyc", 1, 4, 1, 0);
        cfg_valid = 1'b0;
        check_eq("inv1_err",   {31'b0, cfg_err},   32'd1);
        check_eq("inv1_ready", {31'b0, cfg_ready}, 32'd1);
        check_wave("inv1_nxt", 1, 4, 1, 1);
        check_eq("inv1_err_clr", {31'b0, cfg_err}, 32'd0);
        offer(6, 6);
        check_wave("inv2_cyc", 1, 4, 1, 2);
        cfg_valid = 1'b0;
        check_eq("inv2_err",   {31'b0, cfg_err},   32'd1);
        check_eq("inv2_ready", {31'b0, cfg_ready}, 32'd1);
        check_wave("inv2_nxt", 1, 4, 1, 3);
        check_eq("inv2_err_clr", {31'b0, cfg_err}, 32'd0);
        check_wave("inv_keep", 8, 4, 1, 0);

        // Back to 10/5, then config 6/3 accepted on the wrap cycle
        offer(10, 5);
        check_wave("re10_acc", 1, 4, 1, 0);
        cfg_valid = 1'b0;
        check_wave("re10_tail", 3, 4, 1, 1);
        check_eq("re10_ready", {31'b0, cfg_ready}, 32'd1);
        check_wave("re10_run", 9, 10, 5, 0);
        offer(6, 3);
        check_wave("wrap_acc", 1, 10, 5, 9);
        cfg_valid = 1'b0;
        check_eq("wrap_pend", {31'b0, cfg_ready}, 32'd0);
        check_wave("wrap_old", 10, 10, 5, 0);
        check_eq("wrap_ready", {31'b0, cfg_ready}, 32'd1);
        check_wave("p6h3", 12, 6, 3, 0);

        // en dropped at cnt=2, then re-asserted
        check_wave("en_pre", 2, 6, 3, 0);
        en = 1'b0;
        check_wave("en_drop", 1, 6, 3, 2);
        check_eq("idle_out",  {31'b0, clk_div_out}, 32'd0);
        check_eq("idle_tick", {31'b0, tick},        32'd0);
        step();
        check_eq("idle2_out", {31'b0, clk_div_out}, 32'd0);
        en = 1'b1;
        step();
        check_wave("en_back", 6, 6, 3, 0);

        // en falling in the same cycle as a valid transfer: applies from IDLE
        check_wave("fall_pre", 1, 6, 3, 0);
        en = 1'b0;
        offer(4, 2);
        check_wave("fall_acc", 1, 6, 3, 1);
        cfg_valid = 1'b0;
        check_eq("fall_pend", {31'b0, cfg_ready},   32'd0);
        check_eq("fall_out",  {31'b0, clk_div_out}, 32'd0);
        step();
        check_eq("fall_apply", {31'b0, cfg_ready}, 32'd1);
        en = 1'b1;
        step();
        check_wave("p4h2", 8, 4, 2, 0);

        // Reset mid-period with a config pending
        check_wave("rst_pre", 1, 4, 2, 0);
        offer(8, 4);
        check_wave("rst_acc", 1, 4, 2, 1);
        cfg_valid = 1'b0;
        check_eq("rst_pend", {31'b0, cfg_ready}, 32'd0);
        rst_n = 1'b0;
        step();
        check_eq("mrst_ready", {31'b0, cfg_ready},   32'd1);
        check_eq("mrst_out",   {31'b0, clk_div_out}, 32'd0);
        check_eq("mrst_tick",  {31'b0, tick},        32'd0);
        rst_n = 1'b1;
        step();
        check_wave("mrst_dflt", 20, 10, 5, 0);

`ifdef CLKDIV_CYC_COUNT_EN
        // 300 periods at 2/1, then hold across en=0
        en    = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("cyc_clr", {24'b0, cyc_count}, 32'd0);
        offer(2, 1);
        step();
        cfg_valid = 1'b0;
        step();
        check_eq("cyc_cfg_ready", {31'b0, cfg_ready}, 32'd1);
        en = 1'b1;
        step();
        check_wave("p2h1", 4, 2, 1, 0);
        for (int i = 0; i < 596; i++) step();
        check_eq("cyc_300", {24'b0, cyc_count}, 32'd44);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("cyc_hold", {24'b0, cyc_count}, 32'd44);
        en = 1'b1;
        step();
        step();
        step();
        check_eq("cyc_resume", {24'b0, cyc_count}, 32'd45);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
